// File: rtl/spi_arbiter_if.sv
// ---------------------------------------------------------------------------
// spi_arbiter_if
//
// Bundles every handshake and data signal between the client side, the
// spi_arbiter and the shared spi_master. Clock and reset are separate plain
// ports of the arbiter.
//
// Parameters:
//   N_CLIENTS  - number of requesters sharing the master (>= 2)
//   DATA_WIDTH - SPI word width, must match the spi_master instance
//
// Client-side signals:
//   req_data   - packed client words, client i in [i*DATA_WIDTH +: DATA_WIDTH]
//   req_valid  - per-client transfer request, data held stable until ready
//   req_ready  - per-client one-cycle pulse, word accepted by the master
//   rsp_data   - received word for the granted client
//   rsp_valid  - one-hot, rsp_data is valid for that client
//   rsp_ready  - per-client response consume
//
// Master-side signals:
//   m_data_in, m_data_in_valid, m_data_in_ack    - load handshake
//   m_data_out, m_data_out_valid, m_data_out_ack - result handshake
//   m_ss_n                                       - master slave select
//
// Status signals:
//   ss_n       - per-slave select decoded from m_ss_n and the grant
//   grant_idx  - current or last granted client
//   busy       - arbiter is not idle
//
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (clients plus spi_master)
// ---------------------------------------------------------------------------
interface spi_arbiter_if #(
    parameter int N_CLIENTS  = 4,
    parameter int DATA_WIDTH = 8
);

    localparam int IDX_W = $clog2(N_CLIENTS);

    logic [N_CLIENTS*DATA_WIDTH-1:0] req_data;
    logic [N_CLIENTS-1:0]            req_valid;
    logic [N_CLIENTS-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]           rsp_data;
    logic [N_CLIENTS-1:0]            rsp_valid;
    logic [N_CLIENTS-1:0]            rsp_ready;

    logic [DATA_WIDTH-1:0]           m_data_in;
    logic                            m_data_in_valid;
    logic                            m_data_in_ack;
    logic [DATA_WIDTH-1:0]           m_data_out;
    logic                            m_data_out_valid;
    logic                            m_data_out_ack;
    logic                            m_ss_n;

    logic [N_CLIENTS-1:0]            ss_n;
    logic [IDX_W-1:0]                grant_idx;
    logic                            busy;

    modport slave (
        input  req_data,
        input  req_valid,
        input  rsp_ready,
        input  m_data_in_ack,
        input  m_data_out,
        input  m_data_out_valid,
        input  m_ss_n,
        output req_ready,
        output rsp_data,
        output rsp_valid,
        output m_data_in,
        output m_data_in_valid,
        output m_data_out_ack,
        output ss_n,
        output grant_idx,
        output busy
    );

    modport master (
        output req_data,
        output req_valid,
        output rsp_ready,
        output m_data_in_ack,
        output m_data_out,
        output m_data_out_valid,
        output m_ss_n,
        input  req_ready,
        input  rsp_data,
        input  rsp_valid,
        input  m_data_in,
        input  m_data_in_valid,
        input  m_data_out_ack,
        input  ss_n,
        input  grant_idx,
        input  busy
    );

endinterface

// File: rtl/spi_arbiter.sv
// ---------------------------------------------------------------------------
// spi_arbiter
//
// Shares one spi_master among N_CLIENTS requesters, one full-duplex word
// transfer at a time. Picks a winner among pending requests, runs the
// master's load/ack and result/ack handshakes, returns the received word to
// the granted client and decodes the master's single SS_n into per-client
// slave selects.
//
// Parameters:
//   N_CLIENTS  - number of requesters (>= 2)
//   DATA_WIDTH - word width, must match spi_master
//
// Ports:
//   clk   - system clock, shared with spi_master
//   rst_n - asynchronous active-low reset
//   bus   - spi_arbiter_if.slave, all client and master handshakes
//
// Configuration macro:
//   SPI_ARB_ROUND_ROBIN_EN - defined: round-robin arbitration starting at a
//                            pointer that advances after each completed
//                            transfer. Undefined: fixed priority, lowest
//                            index wins, no pointer register.
// ---------------------------------------------------------------------------
module spi_arbiter #(
    parameter int N_CLIENTS  = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    spi_arbiter_if.slave  bus
);

    localparam int IDX_W = $clog2(N_CLIENTS);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        XFER,
        RESP,
        DRAIN
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic [N_CLIENTS-1:0]  grant;
    logic [IDX_W-1:0]      grant_idx_q;
    logic [DATA_WIDTH-1:0] m_data_in_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;

    logic                  req_any;
    logic [IDX_W-1:0]      winner;
    logic [N_CLIENTS-1:0]  winner_onehot;
    logic                  rsp_ready_granted;
    logic                  drain_done;

    // Leaving DRAIN marks a completed transfer; the round-robin pointer
    // advances on exactly this condition.
    assign drain_done = (state == DRAIN) && !bus.m_data_out_valid;

`ifdef SPI_ARB_ROUND_ROBIN_EN

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_nxt;
    logic [IDX_W-1:0] cand;

    // The next pointer is the slot after the client just served, wrapping
    // at N_CLIENTS, which need not be a power of two.
    assign ptr_nxt = (grant_idx_q == IDX_W'(N_CLIENTS - 1)) ? '0 : grant_idx_q + 1'b1;

    // Search upward from the pointer with wrap; the first requester found
    // wins, so every client gets a turn before anyone is served twice.
    always_comb begin
        req_any = 1'b0;
        winner  = '0;
        cand    = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            cand = IDX_W'((int'(ptr) + i) % N_CLIENTS);
            if (!req_any && bus.req_valid[cand]) begin
                req_any = 1'b1;
                winner  = cand;
            end
        end
    end

    // Pointer register, only moved once a transfer has fully drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (drain_done) begin
            ptr <= ptr_nxt;
        end
    end

`else

    // Fixed priority: walking down from the top lets the lowest requesting
    // index overwrite everyone above it.
    always_comb begin
        req_any = |bus.req_valid;
        winner  = '0;
        for (int i = N_CLIENTS - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                winner = IDX_W'(i);
            end
        end
    end

`endif

    // One-hot form of the winner, registered as the grant vector.
    always_comb begin
        winner_onehot         = '0;
        winner_onehot[winner] = 1'b1;
    end

    // Only the granted client's rsp_ready matters; all others are masked.
    assign rsp_ready_granted = |(bus.rsp_ready & grant);

    // Next-state logic. XFER is only entered with the master's result valid
    // low, because DRAIN waits for it to clear before returning to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_any) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (bus.m_data_in_ack) begin
                    state_nxt = XFER;
                end
            end
            XFER: begin
                if (bus.m_data_out_valid) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_granted) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!bus.m_data_out_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant and outgoing word are captured together when a winner is picked,
    // so the client may change its slice once req_ready has pulsed. The grant
    // is kept after the transfer so grant_idx reports the last client served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant       <= '0;
            grant_idx_q <= '0;
            m_data_in_q <= '0;
        end else if (state == IDLE && req_any) begin
            grant       <= winner_onehot;
            grant_idx_q <= winner;
            m_data_in_q <= bus.req_data[winner*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Response word is captured the cycle the master reports it valid and is
    // held through RESP however long the client stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_q <= '0;
        end else if (state == XFER && bus.m_data_out_valid) begin
            rsp_data_q <= bus.m_data_out;
        end
    end

    // Handshake outputs are pure state decodes. m_data_out_ack covers both
    // XFER and RESP so the master cannot drop its result before the client
    // has taken it.
    assign bus.m_data_in       = m_data_in_q;
    assign bus.m_data_in_valid = (state == LOAD);
    assign bus.req_ready       = (state == LOAD && bus.m_data_in_ack) ? grant : '0;
    assign bus.m_data_out_ack  = (state == XFER) || (state == RESP);
    assign bus.rsp_valid       = (state == RESP) ? grant : '0;
    assign bus.rsp_data        = rsp_data_q;
    assign bus.grant_idx       = grant_idx_q;
    assign bus.busy            = (state != IDLE);

    // Per-slave select follows the master's SS_n with no added latency; a
    // cleared grant vector after reset leaves every select deasserted.
    assign bus.ss_n = {N_CLIENTS{bus.m_ss_n}} | ~grant;

endmodule

// File: tb/tb_spi_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spi_arbiter
//
// Directed bench for spi_arbiter. A small behavioural stand-in for
// spi_master acks a load one cycle after seeing valid, shifts the word out
// LSB first for DATA_WIDTH cycles with SS_n low, then presents its result
// until the arbiter drops data_out_ack. Client behaviour is a single linear
// sequence of steps with hand-computed expectations.
//
// Honours SPI_ARB_ROUND_ROBIN_EN for the expected grant order.
// ---------------------------------------------------------------------------
module tb_spi_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    spi_arbiter_if #(.N_CLIENTS(N), .DATA_WIDTH(DW)) bus ();

    spi_arbiter #(.N_CLIENTS(N), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Master stand-in state.
    typedef enum logic [1:0] {M_IDLE, M_ACK, M_SHIFT, M_DONE} mst_t;
    mst_t          mst;
    logic [DW-1:0] miso_word;
    logic [DW-1:0] tx_sr;
    logic [DW-1:0] rx_sr;
    logic [DW-1:0] last_mosi;
    int            bit_cnt;
    int            load_count = 0;
    logic          overlap_seen = 1'b0;

    // Behavioural spi_master: rx_sr rebuilds the MOSI stream LSB first so
    // last_mosi shows what the wire actually carried.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mst                  <= M_IDLE;
            bus.m_data_in_ack    <= 1'b0;
            bus.m_ss_n           <= 1'b1;
            bus.m_data_out_valid <= 1'b0;
            bus.m_data_out       <= '0;
            tx_sr                <= '0;
            rx_sr                <= '0;
            last_mosi            <= '0;
            bit_cnt              <= 0;
        end else begin
            if (bus.m_data_in_valid && bus.m_data_out_valid) begin
                overlap_seen <= 1'b1;
            end
            case (mst)
                M_IDLE: begin
                    if (bus.m_data_in_valid) begin
                        bus.m_data_in_ack <= 1'b1;
                        tx_sr             <= bus.m_data_in;
                        load_count        <= load_count + 1;
                        mst               <= M_ACK;
                    end
                end
                M_ACK: begin
                    bus.m_data_in_ack <= 1'b0;
                    bus.m_ss_n        <= 1'b0;
                    bit_cnt           <= 0;
                    mst               <= M_SHIFT;
                end
                M_SHIFT: begin
                    tx_sr   <= tx_sr >> 1;
                    rx_sr   <= {tx_sr[0], rx_sr[DW-1:1]};
                    bit_cnt <= bit_cnt + 1;
                    if (bit_cnt == DW - 1) begin
                        bus.m_ss_n           <= 1'b1;
                        bus.m_data_out_valid <= 1'b1;
                        bus.m_data_out       <= miso_word;
                        last_mosi            <= {tx_sr[0], rx_sr[DW-1:1]};
                        mst                  <= M_DONE;
                    end
                end
                default: begin
                    if (!bus.m_data_out_ack) begin
                        bus.m_data_out_valid <= 1'b0;
                        mst                  <= M_IDLE;
                    end
                end
            endcase
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input int client, input logic [DW-1:0] data);
        bus.req_data[client*DW +: DW] = data;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (bus.req_ready == '0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_output(tag, {31'b0, bus.req_ready != '0}, 32'd1);
    endtask

    task automatic wait_rsp(input string tag, input int client, output int n);
        n = 0;
        while (!bus.rsp_valid[client] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_output(tag, {31'b0, bus.rsp_valid[client]}, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_output(tag, {31'b0, bus.busy}, 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int n;
        int exp_client;
        int loads_before;

        rst_n         = 1'b0;
        bus.req_data  = '0;
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        miso_word     = '0;

        // Reset values.
        repeat (3) @(negedge clk);
        check_output("rst_busy",      {31'b0, bus.busy},            32'd0);
        check_output("rst_ss_n",      {28'b0, bus.ss_n},            32'hF);
        check_output("rst_rsp_valid", {28'b0, bus.rsp_valid},       32'h0);
        check_output("rst_req_ready", {28'b0, bus.req_ready},       32'h0);
        check_output("rst_in_valid",  {31'b0, bus.m_data_in_valid}, 32'd0);
        check_output("rst_out_ack",   {31'b0, bus.m_data_out_ack},  32'd0);
        check_output("rst_rsp_data",  {24'b0, bus.rsp_data},        32'h0);
        check_output("rst_m_data_in", {24'b0, bus.m_data_in},       32'h0);
        check_output("rst_grant_idx", {30'b0, bus.grant_idx},       32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request from client 2: 0xA5 out, 0x3C back.
        $display("[TB] single request, client 2");
        apply_stimulus(2, 8'hA5);
        miso_word     = 8'h3C;
        bus.req_valid = 4'b0100;
        @(negedge clk);
        check_output("s1_busy",      {31'b0, bus.busy},            32'd1);
        check_output("s1_in_valid",  {31'b0, bus.m_data_in_valid}, 32'd1);
        check_output("s1_m_data_in", {24'b0, bus.m_data_in},       32'hA5);
        check_output("s1_grant_idx", {30'b0, bus.grant_idx},       32'd2);
        check_output("s1_no_ready",  {28'b0, bus.req_ready},       32'h0);
        @(negedge clk);
        check_output("s1_req_ready", {28'b0, bus.req_ready},       32'b0100);
        bus.req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        check_output("s1_ss_n",      {28'b0, bus.ss_n},            32'b1011);
        check_output("s1_out_ack",   {31'b0, bus.m_data_out_ack},  32'd1);
        check_output("s1_in_low",    {31'b0, bus.m_data_in_valid}, 32'd0);
        wait_rsp("s1_rsp_timeout", 2, n);
        check_output("s1_latency",   4 + n,                        32'd12);
        check_output("s1_rsp_valid", {28'b0, bus.rsp_valid},       32'b0100);
        check_output("s1_rsp_data",  {24'b0, bus.rsp_data},        32'h3C);
        check_output("s1_mosi",      {24'b0, last_mosi},           32'hA5);
        bus.rsp_ready = 4'b0100;
        @(negedge clk);
        check_output("s1_rsp_drop",  {28'b0, bus.rsp_valid},       32'h0);
        check_output("s1_ack_drop",  {31'b0, bus.m_data_out_ack},  32'd0);
        check_output("s1_drain_bsy", {31'b0, bus.busy},            32'd1);
        bus.rsp_ready = '0;
        wait_idle("s1_idle_timeout");

        // Client 1 stalls its response 20 cycles while clients 0 and 3
        // toggle their request/consume lines.
        $display("[TB] response backpressure, client 1");
        apply_stimulus(1, 8'h5A);
        apply_stimulus(0, 8'h11);
        miso_word     = 8'hC3;
        bus.req_valid = 4'b0010;
        wait_req("bp_req_timeout");
        check_output("bp_req_ready", {28'b0, bus.req_ready}, 32'b0010);
        bus.req_valid = '0;
        wait_rsp("bp_rsp_timeout", 1, n);
        for (int c = 0; c < 20; c++) begin
            bus.rsp_ready[3] = ~bus.rsp_ready[3];
            bus.rsp_ready[0] = ~bus.rsp_ready[0];
            bus.req_valid[0] = ~bus.req_valid[0];
            @(negedge clk);
            check_output("bp_rsp_valid", {28'b0, bus.rsp_valid},       32'b0010);
            check_output("bp_rsp_data",  {24'b0, bus.rsp_data},        32'hC3);
            check_output("bp_out_ack",   {31'b0, bus.m_data_out_ack},  32'd1);
            check_output("bp_busy",      {31'b0, bus.busy},            32'd1);
            check_output("bp_grant_idx", {30'b0, bus.grant_idx},       32'd1);
            check_output("bp_in_valid",  {31'b0, bus.m_data_in_valid}, 32'd0);
        end
        bus.req_valid = '0;
        bus.rsp_ready = 4'b0010;
        @(negedge clk);
        check_output("bp_rsp_drop", {28'b0, bus.rsp_valid}, 32'h0);
        check_output("bp_mosi",     {24'b0, last_mosi},     32'h5A);
        bus.rsp_ready = '0;
        wait_idle("bp_idle_timeout");

        // Reset asserted while client 0 is shifting.
        $display("[TB] reset mid-transfer");
        apply_stimulus(0, 8'h3E);
        miso_word     = 8'h12;
        bus.req_valid = 4'b0001;
        wait_req("rx_req_timeout");
        bus.req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        check_output("rx_in_xfer",   {31'b0, bus.m_data_out_ack},  32'd1);
        rst_n = 1'b0;
        #1;
        check_output("rx_busy",      {31'b0, bus.busy},            32'd0);
        check_output("rx_ss_n",      {28'b0, bus.ss_n},            32'hF);
        check_output("rx_out_ack",   {31'b0, bus.m_data_out_ack},  32'd0);
        check_output("rx_in_valid",  {31'b0, bus.m_data_in_valid}, 32'd0);
        check_output("rx_rsp_valid", {28'b0, bus.rsp_valid},       32'h0);
        check_output("rx_m_data_in", {24'b0, bus.m_data_in},       32'h0);
        check_output("rx_grant_idx", {30'b0, bus.grant_idx},       32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        apply_stimulus(1, 8'h6D);
        miso_word     = 8'h81;
        bus.req_valid = 4'b0010;
        wait_req("rx2_req_timeout");
        check_output("rx2_req_ready", {28'b0, bus.req_ready}, 32'b0010);
        bus.req_valid = '0;
        wait_rsp("rx2_rsp_timeout", 1, n);
        check_output("rx2_rsp_data",  {24'b0, bus.rsp_data},  32'h81);
        check_output("rx2_mosi",      {24'b0, last_mosi},     32'h6D);
        bus.rsp_ready = 4'b0010;
        @(negedge clk);
        bus.rsp_ready = '0;
        wait_idle("rx2_idle_timeout");

        // All four clients request continuously; pointer starts from reset.
        $display("[TB] simultaneous requests");
        pulse_reset();
        for (int i = 0; i < N; i++) begin
            apply_stimulus(i, 8'h10 + 8'(i));
        end
        bus.rsp_ready = 4'hF;
        bus.req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
`ifdef SPI_ARB_ROUND_ROBIN_EN
            exp_client = k % N;
`else
            exp_client = 0;
`endif
            wait_req("ar_req_timeout");
            check_output("ar_grant",     {28'b0, bus.req_ready}, 32'(1 << exp_client));
            check_output("ar_m_data_in", {24'b0, bus.m_data_in}, 32'h10 + 32'(exp_client));
            miso_word = 8'h40 + 8'(k);
            if (k == 4) begin
                bus.req_valid = '0;
            end
            wait_rsp("ar_rsp_timeout", exp_client, n);
            check_output("ar_rsp_data",  {24'b0, bus.rsp_data},  32'h40 + 32'(k));
            @(negedge clk);
        end
        bus.rsp_ready = '0;
        wait_idle("ar_idle_timeout");

        // Back-to-back requests from client 3 with a fresh word each time.
        $display("[TB] back-to-back, client 3");
        loads_before  = load_count;
        apply_stimulus(3, 8'h77);
        miso_word     = 8'h99;
        bus.rsp_ready = 4'b1000;
        bus.req_valid = 4'b1000;
        wait_req("bb1_req_timeout");
        check_output("bb1_req_ready", {28'b0, bus.req_ready}, 32'b1000);
        apply_stimulus(3, 8'h88);
        wait_rsp("bb1_rsp_timeout", 3, n);
        check_output("bb1_rsp_data",  {24'b0, bus.rsp_data},  32'h99);
        check_output("bb1_mosi",      {24'b0, last_mosi},     32'h77);
        miso_word = 8'hAA;
        wait_req("bb2_req_timeout");
        check_output("bb2_req_ready", {28'b0, bus.req_ready}, 32'b1000);
        check_output("bb2_m_data_in", {24'b0, bus.m_data_in}, 32'h88);
        bus.req_valid = '0;
        wait_rsp("bb2_rsp_timeout", 3, n);
        check_output("bb2_rsp_data",  {24'b0, bus.rsp_data},  32'hAA);
        check_output("bb2_mosi",      {24'b0, last_mosi},     32'h88);
        @(negedge clk);
        bus.rsp_ready = '0;
        wait_idle("bb_idle_timeout");
        check_output("bb_load_count", 32'(load_count - loads_before), 32'd2);
        check_output("no_overlap",    {31'b0, overlap_seen},          32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Backstop in case a wait escapes its own bound.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
